uart_core_p: RTL
================

# uart_core_p

Parametrised UART transceiver for the monitor subsystem, successor to the fixed-size UART interface. Provides 8N1 (optionally 8E1) serial TX/RX with baud divisor and FIFO depth set by parameters, and sticky error flags. Adds a second TX source: a single-entry CPU character port merged into the TX FIFO. Sits between the board `rx`/`tx` pins and the monitor's loop/command logic.

## Interface
- `BAUD_DIV`, 434, clocks per serial bit (50 MHz / 115200); legal range ≥ 4.
- `FIFO_AW`, 3, FIFO address width; each FIFO holds 2^FIFO_AW bytes.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx` in 1: serial input, asynchronous to `clk`.
- `tx` out 1: serial output, idle high.
- `rx_rden` in 1: pop the RX FIFO head.
- `rx_rdata` out 8: RX FIFO head (show-ahead), valid while `rx_fifo_dvalid`.
- `rx_fifo_dvalid` out 1: RX FIFO non-empty.
- `rx_fifo_full` out 1: RX FIFO full.
- `rx_fifo_cnt` out FIFO_AW+1: RX occupancy.
- `rx_fifo_overrun`, `rx_fifo_underrun`, `rx_frame_err` out 1 each: sticky error flags.
- `tx_wdata` in 8, `tx_wten` in 1: monitor channel (ch0) write.
- `tx_fifo_full` out 1: TX FIFO full.
- `tx_fifo_overrun` out 1: sticky flag.
- `uart_io_char` in 8, `uart_io_we` in 1: CPU channel (ch1) write.
- `uart_io_full` out 1: ch1 holding register occupied.
- `err_clr` in 1: clears all sticky flags.

## Operation
- RX path:
  - `rx` passes through a 2-flop synchroniser; the state machine sees it 2 cycles late.
  - States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: a synchronised falling edge loads the bit counter with BAUD_DIV/2 (integer divide) and enters START.
  - START: at expiry, samples `rx`. High = glitch, return to IDLE with nothing recorded. Low = enter DATA.
  - DATA: samples 8 bits LSB first, one every BAUD_DIV cycles.
  - STOP: samples the stop bit. 1 → push byte to FIFO. 0 → set `rx_frame_err`, drop the byte, return to IDLE.
  - Push while full with no same-cycle pop → set `rx_fifo_overrun`, drop the byte.
  - Pop while empty → set `rx_fifo_underrun`; pointers do not move.
  - Push and pop in the same cycle on a full FIFO: both succeed, no overrun.
- TX path:
  - States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - Leaves IDLE when the TX FIFO is non-empty: pops one byte and drives start (0), then 8 data bits LSB first, then stop (1). Each bit lasts BAUD_DIV cycles.
  - Back-to-back frames: no idle bit between STOP and the next START.
- TX merge, ch0 and ch1:
  - ch0 writes go straight to the FIFO. A write while full sets `tx_fifo_overrun` and drops the byte.
  - `uart_io_we` loads the ch1 holding register (HR) and sets `uart_io_full`.
  - HR moves into the FIFO on any cycle with no `tx_wten` and a non-full FIFO.
  - `uart_io_we` while `uart_io_full` is ignored.
  - ch0 wins a same-cycle conflict; ch1 is never dropped.
- Sticky flags:
  - Cleared by `err_clr`.
  - A set event in the same cycle as `err_clr` wins: the flag ends at 1.
- Counters: 2^FIFO_AW depth; pointers FIFO_AW+1 bits with wrap bit; full = MSBs differ and LSBs equal.

## Timing
- Reset values: `tx`=1; every flag, `rx_rdata`, `rx_fifo_cnt`, `uart_io_full`, `rx_fifo_dvalid` = 0; both FSMs in IDLE; HR empty.
- Reset mid-frame aborts immediately: `tx`=1, and FIFO contents are lost.
- TX latency: `tx_wten` at cycle N into an empty FIFO with idle TX gives the start bit on `tx` at cycle N+2. The frame is 10×BAUD_DIV cycles (11× with parity).
- RX latency: `rx_fifo_dvalid` rises 1 cycle after the stop-bit sample. That sample lands ≈ 2 + 9.5×BAUD_DIV cycles after the start edge.
- `rx_rdata` updates the cycle after a pop.
- `uart_io_full` falls the cycle after the HR drains.

## Configuration
- `UART_PARITY_EN` defined:
  - TX inserts an even-parity bit after bit 7.
  - RX samples a parity bit; on mismatch it sets `rx_frame_err` and drops the byte.
  - Frame is 11 bits.
- Undefined: 8N1 only, with no PARITY states.

## Test plan
All scenarios use BAUD_DIV=8, FIFO_AW=2.
- Loopback `tx`→`rx`; write 0x55 via ch0 → `tx` shows 0,1,0,1,0,1,0,1,0,1 at 8 cycles/bit; RX FIFO head = 0x55, `rx_fifo_cnt`=1.
- Drive 5 frames 0x01–0x05 with no pops → FIFO holds 0x01–0x04, `rx_fifo_overrun`=1. Pop 4 → 0x01..0x04 in order. Pop again → `rx_fifo_underrun`=1.
- Frame 0xA3 with stop bit 0 → `rx_frame_err`=1 and FIFO empty. A 2-cycle low glitch on `rx` → no flags, FSM back in IDLE.
- Same-cycle ch0=0x41 and ch1=0x42 → `uart_io_full`=1 for 1 cycle; transmitted order is 0x41 then 0x42.
- Fill the TX FIFO with 4 bytes, write a 5th → `tx_fifo_overrun`=1. `err_clr` plus a simultaneous new overrun → flag stays 1.
- With `UART_PARITY_EN`: 0x07 → parity bit 1 on `tx`. Inject a flipped parity bit on RX → `rx_frame_err`=1, byte dropped.

Source files
------------

// File: rtl/uart_core_p.sv
// -----------------------------------------------------------------------------
// uart_core_p
// Parametrised UART transceiver (8N1, optionally 8E1) with RX and TX FIFOs,
// sticky error flags and a second TX source: a single-entry CPU character
// holding register (ch1) that merges into the TX FIFO behind the monitor
// channel (ch0).
//
// Optional feature macro: UART_PARITY_EN
//   defined   -> even-parity bit after data bit 7 on TX, checked on RX (8E1)
//   undefined -> 8N1 only
//
// Parameters
//   BAUD_DIV  clocks per serial bit (>= 4)
//   FIFO_AW   FIFO address width, each FIFO holds 2**FIFO_AW bytes
//
// Ports
//   clk, rst_n                single clock, asynchronous active-low reset
//   rx / tx                   serial in (async to clk) / serial out (idle high)
//   rx_rden                   pop RX FIFO head
//   rx_rdata                  RX FIFO head (show-ahead), valid with rx_fifo_dvalid
//   rx_fifo_dvalid/full/cnt   RX FIFO status
//   rx_fifo_overrun/underrun  sticky RX FIFO error flags
//   rx_frame_err              sticky framing / parity error flag
//   tx_wdata, tx_wten         ch0 write into TX FIFO
//   tx_fifo_full              TX FIFO full
//   tx_fifo_overrun           sticky flag, ch0 write dropped while full
//   uart_io_char, uart_io_we  ch1 write into the holding register
//   uart_io_full              ch1 holding register occupied
//   err_clr                   clears all sticky flags (a same-cycle set wins)
// -----------------------------------------------------------------------------
module uart_core_p #(
    parameter int BAUD_DIV = 434,
    parameter int FIFO_AW  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx,
    output logic               tx,
    input  logic               rx_rden,
    output logic [7:0]         rx_rdata,
    output logic               rx_fifo_dvalid,
    output logic               rx_fifo_full,
    output logic [FIFO_AW:0]   rx_fifo_cnt,
    output logic               rx_fifo_overrun,
    output logic               rx_fifo_underrun,
    output logic               rx_frame_err,
    input  logic [7:0]         tx_wdata,
    input  logic               tx_wten,
    output logic               tx_fifo_full,
    output logic               tx_fifo_overrun,
    input  logic [7:0]         uart_io_char,
    input  logic               uart_io_we,
    output logic               uart_io_full,
    input  logic               err_clr
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] BIT_CNT  = CW'(BAUD_DIV);
    localparam logic [CW-1:0] HALF_CNT = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] ONE      = CW'(1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    // ------------------------------------------------------------------
    // RX synchroniser and receive FSM
    // ------------------------------------------------------------------
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    state_t        rx_st_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_sh_q;
    logic          rx_push_q;
    logic [7:0]    rx_byte_q;
    logic          rx_ferr_q;
`ifdef UART_PARITY_EN
    logic          rx_par_ok_q;
`endif
    logic          rx_exp;

    assign rx_exp = (rx_cnt_q == ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // The counter counts down to 1; the sample is taken on that cycle and
    // the counter reloads, so consecutive samples are BAUD_DIV cycles apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st_q   <= S_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_push_q <= 1'b0;
            rx_byte_q <= '0;
            rx_ferr_q <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_ok_q <= 1'b0;
`endif
        end else begin
            rx_push_q <= 1'b0;
            rx_ferr_q <= 1'b0;
            if (rx_st_q == S_IDLE) begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_cnt_q <= HALF_CNT;
                    rx_st_q  <= S_START;
                end
            end else if (!rx_exp) begin
                rx_cnt_q <= rx_cnt_q - ONE;
            end else begin
                rx_cnt_q <= BIT_CNT;
                case (rx_st_q)
                    S_START: begin
                        // High at mid start bit means it was a glitch
                        if (rx_sync_q) begin
                            rx_st_q <= S_IDLE;
                        end else begin
                            rx_bit_q <= '0;
                            rx_st_q  <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        rx_sh_q  <= {rx_sync_q, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            rx_st_q <= S_PARITY;
`else
                            rx_st_q <= S_STOP;
`endif
                        end
                    end
`ifdef UART_PARITY_EN
                    S_PARITY: begin
                        rx_par_ok_q <= (rx_sync_q == ^rx_sh_q);
                        rx_st_q     <= S_STOP;
                    end
`endif
                    S_STOP: begin
                        rx_st_q <= S_IDLE;
`ifdef UART_PARITY_EN
                        if (rx_sync_q && rx_par_ok_q) begin
`else
                        if (rx_sync_q) begin
`endif
                            rx_push_q <= 1'b1;
                            rx_byte_q <= rx_sh_q;
                        end else begin
                            rx_ferr_q <= 1'b1;
                        end
                    end
                    default: rx_st_q <= S_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]     rx_mem_q [DEPTH];
    logic [FIFO_AW:0] rx_wptr_q, rx_rptr_q, rx_wptr_d, rx_rptr_d;
    logic           rx_empty, rx_full, rx_do_push, rx_do_pop;

    assign rx_empty   = (rx_wptr_q == rx_rptr_q);
    assign rx_full    = (rx_wptr_q[FIFO_AW] != rx_rptr_q[FIFO_AW]) &&
                        (rx_wptr_q[FIFO_AW-1:0] == rx_rptr_q[FIFO_AW-1:0]);
    assign rx_do_pop  = rx_rden && !rx_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign rx_do_push = rx_push_q && (!rx_full || rx_do_pop);
    assign rx_wptr_d  = rx_wptr_q + {{FIFO_AW{1'b0}}, rx_do_push};
    assign rx_rptr_d  = rx_rptr_q + {{FIFO_AW{1'b0}}, rx_do_pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_do_push) rx_mem_q[rx_wptr_q[FIFO_AW-1:0]] <= rx_byte_q;
    end

    assign rx_fifo_dvalid = !rx_empty;
    assign rx_fifo_full   = rx_full;
    assign rx_fifo_cnt    = rx_wptr_q - rx_rptr_q;
    assign rx_rdata       = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q[FIFO_AW-1:0]];

    // ------------------------------------------------------------------
    // TX merge: ch0 direct, ch1 via holding register
    // ------------------------------------------------------------------
    logic [7:0]     tx_mem_q [DEPTH];
    logic [FIFO_AW:0] tx_wptr_q, tx_rptr_q, tx_wptr_d, tx_rptr_d;
    logic           tx_empty, tx_full, tx_do_push, tx_pop, hr_drain;
    logic [7:0]     tx_push_data, tx_fifo_rd;
    logic           hr_full_q;
    logic [7:0]     hr_q;

    assign tx_empty     = (tx_wptr_q == tx_rptr_q);
    assign tx_full      = (tx_wptr_q[FIFO_AW] != tx_rptr_q[FIFO_AW]) &&
                          (tx_wptr_q[FIFO_AW-1:0] == tx_rptr_q[FIFO_AW-1:0]);
    // ch1 only gets the FIFO write port on cycles ch0 leaves idle
    assign hr_drain     = hr_full_q && !tx_wten && !tx_full;
    assign tx_do_push   = (tx_wten && !tx_full) || hr_drain;
    assign tx_push_data = tx_wten ? tx_wdata : hr_q;
    assign tx_fifo_rd   = tx_mem_q[tx_rptr_q[FIFO_AW-1:0]];
    assign tx_wptr_d    = tx_wptr_q + {{FIFO_AW{1'b0}}, tx_do_push};
    assign tx_rptr_d    = tx_rptr_q + {{FIFO_AW{1'b0}}, tx_pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            hr_full_q <= 1'b0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            if (hr_drain)
                hr_full_q <= 1'b0;
            else if (uart_io_we && !hr_full_q)
                hr_full_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_do_push) tx_mem_q[tx_wptr_q[FIFO_AW-1:0]] <= tx_push_data;
        if (uart_io_we && !hr_full_q) hr_q <= uart_io_char;
    end

    assign tx_fifo_full = tx_full;
    assign uart_io_full = hr_full_q;

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    state_t        tx_st_q;
    logic          tx_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_sh_q;
`ifdef UART_PARITY_EN
    logic          tx_par_q;
`endif
    logic          tx_exp;

    assign tx_exp = (tx_cnt_q == ONE);
    // Pop from IDLE, or at the end of STOP so frames run back to back
    assign tx_pop = !tx_empty &&
                    ((tx_st_q == S_IDLE) || ((tx_st_q == S_STOP) && tx_exp));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st_q  <= S_IDLE;
            tx_q     <= 1'b1;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
`ifdef UART_PARITY_EN
            tx_par_q <= 1'b0;
`endif
        end else if (tx_st_q == S_IDLE) begin
            if (tx_pop) begin
                tx_sh_q  <= tx_fifo_rd;
`ifdef UART_PARITY_EN
                tx_par_q <= ^tx_fifo_rd;
`endif
                tx_q     <= 1'b0;
                tx_cnt_q <= BIT_CNT;
                tx_st_q  <= S_START;
            end
        end else if (!tx_exp) begin
            tx_cnt_q <= tx_cnt_q - ONE;
        end else begin
            tx_cnt_q <= BIT_CNT;
            case (tx_st_q)
                S_START: begin
                    tx_q     <= tx_sh_q[0];
                    tx_bit_q <= '0;
                    tx_st_q  <= S_DATA;
                end
                S_DATA: begin
                    if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_q    <= tx_par_q;
                        tx_st_q <= S_PARITY;
`else
                        tx_q    <= 1'b1;
                        tx_st_q <= S_STOP;
`endif
                    end else begin
                        tx_q     <= tx_sh_q[1];
                        tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                        tx_bit_q <= tx_bit_q + 3'd1;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    tx_q    <= 1'b1;
                    tx_st_q <= S_STOP;
                end
`endif
                S_STOP: begin
                    if (tx_pop) begin
                        tx_sh_q  <= tx_fifo_rd;
`ifdef UART_PARITY_EN
                        tx_par_q <= ^tx_fifo_rd;
`endif
                        tx_q     <= 1'b0;
                        tx_st_q  <= S_START;
                    end else begin
                        tx_q     <= 1'b1;
                        tx_st_q  <= S_IDLE;
                    end
                end
                default: tx_st_q <= S_IDLE;
            endcase
        end
    end

    assign tx = tx_q;

    // ------------------------------------------------------------------
    // Sticky flags: set has priority over clear
    // ------------------------------------------------------------------
    logic rx_ovr_q, rx_udr_q, rx_ferr_flag_q, tx_ovr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ovr_q       <= 1'b0;
            rx_udr_q       <= 1'b0;
            rx_ferr_flag_q <= 1'b0;
            tx_ovr_q       <= 1'b0;
        end else begin
            rx_ovr_q       <= (rx_push_q && rx_full && !rx_do_pop) || (rx_ovr_q && !err_clr);
            rx_udr_q       <= (rx_rden && rx_empty) || (rx_udr_q && !err_clr);
            rx_ferr_flag_q <= rx_ferr_q || (rx_ferr_flag_q && !err_clr);
            tx_ovr_q       <= (tx_wten && tx_full) || (tx_ovr_q && !err_clr);
        end
    end

    assign rx_fifo_overrun  = rx_ovr_q;
    assign rx_fifo_underrun = rx_udr_q;
    assign rx_frame_err     = rx_ferr_flag_q;
    assign tx_fifo_overrun  = tx_ovr_q;

endmodule
